sample_frame_reader: RTL

Read-side counterpart to the microphone sampler. It accepts the sampled ADC stream one word per sample strobe and collects it into N-sample frames in a ping-pong buffer. Each completed frame is streamed out with a valid/ready handshake to the downstream consumer (windowing/FFT stage), with an index and a last flag. Sampling continues while a frame is being read out, and frames are dropped explicitly, never corrupted.

---
 rtl/sample_frame_reader_if.sv | 31 +++
 rtl/sample_frame_reader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sample_frame_reader_if.sv
// Bundles the sample input strobe, the frame output stream and the drop status of
// sample_frame_reader.
//   master : the frame reader; takes in_valid/in_data/out_ready, drives out_* and drop status
//   slave  : the environment; drives samples and out_ready, observes the frame stream
interface sample_frame_reader_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned N     = 256,
  parameter int unsigned CNTW  = 16
) ();
  localparam int unsigned IdxW = $clog2(N);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IdxW-1:0]  out_index;
  logic             out_last;
  logic             frame_drop;
  logic [CNTW-1:0]  drop_count;

  modport master (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_index, out_last, frame_drop, drop_count
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_index, out_last, frame_drop, drop_count
  );
endinterface

// File: rtl/sample_frame_reader.sv
// Collects a sample stream into N-sample frames in a two-bank ping-pong buffer and streams
// each completed frame out with a valid/ready handshake. A frame that completes while the
// reader is still busy with the other bank is discarded and counted.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : sample input, frame output stream (data/index/last), drop pulse and counter
module sample_frame_reader #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned N     = 256,
  parameter int unsigned CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  sample_frame_reader_if.master  bus_io
);
  localparam int unsigned IdxW    = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [0:0] {StIdle, StStream} rd_state_e;

  rd_state_e        rd_state_q, rd_state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IdxW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IdxW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             frame_drop_q, frame_drop_d;
  logic [CNTW-1:0]  drop_count_q, drop_count_d;

  // Bank select is the address MSB: {bank, ptr}.
  logic [WIDTH-1:0] mem_q [2*N];

  logic frame_done;
  logic xfer;
  logic rd_finish;
  logic rd_free;

  assign frame_done = bus_io.in_valid && (wr_ptr_q == LastIdx);
  assign xfer       = (rd_state_q == StStream) && bus_io.out_ready;
  assign rd_finish  = xfer && (rd_ptr_q == LastIdx);
  // Reader can take a new bank if idle or releasing its current one on this edge.
  assign rd_free    = (rd_state_q == StIdle) || rd_finish;

  always_comb begin
    rd_state_d   = rd_state_q;
    wr_bank_d    = wr_bank_q;
    wr_ptr_d     = wr_ptr_q;
    rd_bank_d    = rd_bank_q;
    rd_ptr_d     = rd_ptr_q;
    frame_drop_d = 1'b0;
    drop_count_d = drop_count_q;

    // Pointer wraps N-1 -> 0 naturally since N is a power of two.
    if (bus_io.in_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (frame_done && rd_free) begin
      rd_state_d = StStream;
      rd_bank_d  = wr_bank_q;
      rd_ptr_d   = '0;
      wr_bank_d  = ~wr_bank_q;
    end else begin
      // Dropped frame: keep wr_bank so the next samples overwrite it from index 0.
      if (frame_done) begin
        frame_drop_d = 1'b1;
        if (drop_count_q != {CNTW{1'b1}}) begin
          drop_count_d = drop_count_q + 1'b1;
        end
      end
      if (rd_finish) begin
        rd_state_d = StIdle;
        rd_ptr_d   = '0;
      end else if (xfer) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q   <= StIdle;
      wr_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_ptr_q     <= '0;
      frame_drop_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_bank_q    <= rd_bank_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_drop_q <= frame_drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage is not reset; the read path is gated while idle instead. The writer never
  // targets rd_bank while streaming, so the presented word cannot change under a stall.
  always_ff @(posedge clk) begin
    if (bus_io.in_valid && !rst) begin
      mem_q[{wr_bank_q, wr_ptr_q}] <= bus_io.in_data;
    end
  end

  always_comb begin
    bus_io.out_valid  = (rd_state_q == StStream);
    bus_io.out_data   = '0;
    bus_io.out_index  = '0;
    bus_io.out_last   = 1'b0;
    if (rd_state_q == StStream) begin
      bus_io.out_data  = mem_q[{rd_bank_q, rd_ptr_q}];
      bus_io.out_index = rd_ptr_q;
      bus_io.out_last  = (rd_ptr_q == LastIdx);
    end
    bus_io.frame_drop = frame_drop_q;
    bus_io.drop_count = drop_count_q;
  end
endmodule
